// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: immediate modes, state encoding
// and register-index width.
package alu_issue_stage_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] IMM_RT   = 2'b00;
    localparam logic [1:0] IMM_ZEXT = 2'b01;
    localparam logic [1:0] IMM_SEXT = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream, forwarding and downstream handshake bundle of the ALU issue stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface alu_issue_stage_if
    import alu_issue_stage_pkg::*;
#(
    parameter int n = 32
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_rs_idx;
    logic [n-1:0]         in_rs_val;
    logic [REG_IDX_W-1:0] in_rt_idx;
    logic [n-1:0]         in_rt_val;
    logic [15:0]          in_imm;
    logic [1:0]           in_imm_mode;
    logic [3:0]           in_af;
    logic                 in_i;
    logic [REG_IDX_W-1:0] in_rd_idx;
    logic                 fwd_we;
    logic [REG_IDX_W-1:0] fwd_idx;
    logic [n-1:0]         fwd_val;
    logic                 out_valid;
    logic                 out_ready;
    logic [n-1:0]         out_a;
    logic [n-1:0]         out_b;
    logic [3:0]           out_af;
    logic                 out_i;
    logic [REG_IDX_W-1:0] out_rd_idx;

    modport slave (
        input  flush, in_valid, in_rs_idx, in_rs_val, in_rt_idx, in_rt_val,
               in_imm, in_imm_mode, in_af, in_i, in_rd_idx,
               fwd_we, fwd_idx, fwd_val, out_ready,
        output in_ready, out_valid, out_a, out_b, out_af, out_i, out_rd_idx
    );

    modport master (
        output flush, in_valid, in_rs_idx, in_rs_val, in_rt_idx, in_rt_val,
               in_imm, in_imm_mode, in_af, in_i, in_rd_idx,
               fwd_we, fwd_idx, fwd_val, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_af, out_i, out_rd_idx
    );

endinterface

// File: rtl/alu_issue_stage_operand_select.sv
// Operand resolution: forwarding from the downstream result (never for index 0)
// or zero/sign extension of the immediate.
module operand_select
    import alu_issue_stage_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [n-1:0]         val,
    input  logic [15:0]          imm,
    input  logic [1:0]           imm_mode,
    input  logic                 fwd_we,
    input  logic [REG_IDX_W-1:0] fwd_idx,
    input  logic [n-1:0]         fwd_val,
    output logic [n-1:0]         operand
);

    always_comb begin
        operand = val;
        if (fwd_we && (fwd_idx == idx) && (idx != '0))
            operand = fwd_val;
        // Reserved mode 11 falls through to the register path.
        case (imm_mode)
            IMM_ZEXT: operand = {{(n-16){1'b0}}, imm};
            IMM_SEXT: operand = {{(n-16){imm[15]}}, imm};
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves operands at acceptance and registers them for the ALU.
// Define ALU_ISSUE_SKID_EN for a skid entry that cuts the out_ready -> in_ready path.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int n = 32
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  bus
);

    state_t               state;
    logic [n-1:0]         a_sel;
    logic [n-1:0]         b_sel;
    logic                 accept;
    logic                 drain;

    logic [n-1:0]         out_a_q;
    logic [n-1:0]         out_b_q;
    logic [3:0]           out_af_q;
    logic                 out_i_q;
    logic [REG_IDX_W-1:0] out_rd_q;

    operand_select #(.n(n)) u_sel_a (
        .idx      (bus.in_rs_idx),
        .val      (bus.in_rs_val),
        .imm      ('0),
        .imm_mode (IMM_RT),
        .fwd_we   (bus.fwd_we),
        .fwd_idx  (bus.fwd_idx),
        .fwd_val  (bus.fwd_val),
        .operand  (a_sel)
    );

    operand_select #(.n(n)) u_sel_b (
        .idx      (bus.in_rt_idx),
        .val      (bus.in_rt_val),
        .imm      (bus.in_imm),
        .imm_mode (bus.in_imm_mode),
        .fwd_we   (bus.fwd_we),
        .fwd_idx  (bus.fwd_idx),
        .fwd_val  (bus.fwd_val),
        .operand  (b_sel)
    );

    assign bus.out_valid  = (state != ST_EMPTY);
    assign bus.out_a      = out_a_q;
    assign bus.out_b      = out_b_q;
    assign bus.out_af     = out_af_q;
    assign bus.out_i      = out_i_q;
    assign bus.out_rd_idx = out_rd_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic [n-1:0]         skid_a_q;
    logic [n-1:0]         skid_b_q;
    logic [3:0]           skid_af_q;
    logic                 skid_i_q;
    logic [REG_IDX_W-1:0] skid_rd_q;

    assign bus.in_ready = ~rst & ~bus.flush & (state != ST_SKID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_af_q  <= '0;
            out_i_q   <= 1'b0;
            out_rd_q  <= '0;
            skid_a_q  <= '0;
            skid_b_q  <= '0;
            skid_af_q <= '0;
            skid_i_q  <= 1'b0;
            skid_rd_q <= '0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_FULL: begin
                    if (accept && (drain || state == ST_EMPTY)) begin
                        state    <= ST_FULL;
                        out_a_q  <= a_sel;
                        out_b_q  <= b_sel;
                        out_af_q <= bus.in_af;
                        out_i_q  <= bus.in_i;
                        out_rd_q <= bus.in_rd_idx;
                    end else if (accept) begin
                        state     <= ST_SKID;
                        skid_a_q  <= a_sel;
                        skid_b_q  <= b_sel;
                        skid_af_q <= bus.in_af;
                        skid_i_q  <= bus.in_i;
                        skid_rd_q <= bus.in_rd_idx;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state    <= ST_FULL;
                        out_a_q  <= skid_a_q;
                        out_b_q  <= skid_b_q;
                        out_af_q <= skid_af_q;
                        out_i_q  <= skid_i_q;
                        out_rd_q <= skid_rd_q;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end
`else
    assign bus.in_ready = ~rst & ~bus.flush & (~bus.out_valid | bus.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_a_q  <= '0;
            out_b_q  <= '0;
            out_af_q <= '0;
            out_i_q  <= 1'b0;
            out_rd_q <= '0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            // in_ready already guarantees the held entry drains this cycle.
            state    <= ST_FULL;
            out_a_q  <= a_sel;
            out_b_q  <= b_sel;
            out_af_q <= bus.in_af;
            out_i_q  <= bus.in_i;
            out_rd_q <= bus.in_rd_idx;
        end else if (drain) begin
            state <= ST_EMPTY;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; covers both the default
// build and the ALU_ISSUE_SKID_EN build.
module tb_alu_issue_stage;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_issue_stage_if #(.n(N)) bus ();

    alu_issue_stage #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] rs, input logic [31:0] rs_v,
                          input logic [4:0] rt, input logic [31:0] rt_v,
                          input logic [15:0] imm, input logic [1:0] mode,
                          input logic [3:0] af, input logic i, input logic [4:0] rd);
        bus.in_rs_idx   = rs;
        bus.in_rs_val   = rs_v;
        bus.in_rt_idx   = rt;
        bus.in_rt_val   = rt_v;
        bus.in_imm      = imm;
        bus.in_imm_mode = mode;
        bus.in_af       = af;
        bus.in_i        = i;
        bus.in_rd_idx   = rd;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_we    = 1'b0;
        bus.fwd_idx   = '0;
        bus.fwd_val   = '0;
        set_op(5'd0, 32'h0, 5'd0, 32'h0, 16'h0, 2'b00, 4'h0, 1'b0, 5'd0);

        // Reset state
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_a", bus.out_a, 32'h0);
        check("rst_out_b", bus.out_b, 32'h0);
        check("rst_out_rd", bus.out_rd_idx, 5'd0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // rs forwarded, sign-extended immediate
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.fwd_we    = 1'b1;
        bus.fwd_idx   = 5'd3;
        bus.fwd_val   = 32'h77;
        set_op(5'd3, 32'h5, 5'd0, 32'h0, 16'h8001, 2'b10, 4'hA, 1'b1, 5'd7);
        tick();
        check("fwd_valid", bus.out_valid, 1'b1);
        check("fwd_a", bus.out_a, 32'h77);
        check("sext_b", bus.out_b, 32'hFFFF8001);
        check("fwd_af", bus.out_af, 4'hA);
        check("fwd_i", bus.out_i, 1'b1);
        check("fwd_rd", bus.out_rd_idx, 5'd7);

        // Forward index mismatch, zero-extended immediate, back-to-back accept
        check("full_drain_in_ready", bus.in_ready, 1'b1);
        bus.fwd_idx = 5'd4;
        set_op(5'd3, 32'h5, 5'd0, 32'h0, 16'h8001, 2'b01, 4'h3, 1'b0, 5'd8);
        tick();
        check("nofwd_valid", bus.out_valid, 1'b1);
        check("nofwd_a", bus.out_a, 32'h5);
        check("zext_b", bus.out_b, 32'h00008001);
        check("nofwd_rd", bus.out_rd_idx, 5'd8);

        // Index 0 never forwards
        bus.fwd_idx = 5'd0;
        bus.fwd_val = 32'hDEAD;
        set_op(5'd0, 32'h0, 5'd0, 32'h1234, 16'hFFFF, 2'b00, 4'h1, 1'b0, 5'd9);
        tick();
        check("idx0_a", bus.out_a, 32'h0);
        check("idx0_b", bus.out_b, 32'h1234);

        // rt forwarded, reserved mode treated as register path
        bus.fwd_idx = 5'd9;
        bus.fwd_val = 32'h99;
        set_op(5'd2, 32'h22, 5'd9, 32'h11, 16'h8001, 2'b11, 4'h2, 1'b0, 5'd10);
        tick();
        check("rt_fwd_a", bus.out_a, 32'h22);
        check("rt_fwd_b", bus.out_b, 32'h99);

        // Backpressure: held data stays, no late re-forwarding
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_idx   = 5'd2;
        bus.fwd_val   = 32'h55;
        tick();
        tick();
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_a", bus.out_a, 32'h22);
        check("hold_b", bus.out_b, 32'h99);
        check("hold_rd", bus.out_rd_idx, 5'd10);
`ifdef ALU_ISSUE_SKID_EN
        check("hold_in_ready", bus.in_ready, 1'b1);
`else
        check("hold_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        check("comb_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;
        #1;
`endif

        // Flush from FULL with an incoming operation
        bus.fwd_we   = 1'b0;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        set_op(5'd5, 32'hAB, 5'd0, 32'h0, 16'h0, 2'b00, 4'h0, 1'b0, 5'd11);
        #1;
        check("flush_in_ready", bus.in_ready, 1'b0);
        tick();
        check("flush_valid", bus.out_valid, 1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("flush_not_accepted", bus.out_valid, 1'b0);

`ifdef ALU_ISSUE_SKID_EN
        // Two accepts under backpressure fill the skid entry
        bus.in_valid = 1'b1;
        set_op(5'd1, 32'h101, 5'd0, 32'h0, 16'h0, 2'b00, 4'h4, 1'b0, 5'd1);
        tick();
        check("skid1_a", bus.out_a, 32'h101);
        check("skid1_in_ready", bus.in_ready, 1'b1);
        set_op(5'd1, 32'h202, 5'd0, 32'h0, 16'h0, 2'b00, 4'h5, 1'b1, 5'd2);
        tick();
        check("skid_in_ready", bus.in_ready, 1'b0);
        check("skid_out_a", bus.out_a, 32'h101);
        check("skid_out_rd", bus.out_rd_idx, 5'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("skid2_valid", bus.out_valid, 1'b1);
        check("skid2_a", bus.out_a, 32'h202);
        check("skid2_af", bus.out_af, 4'h5);
        check("skid2_rd", bus.out_rd_idx, 5'd2);
        tick();
        check("skid_empty", bus.out_valid, 1'b0);

        // Reset while in SKID
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(5'd1, 32'h303, 5'd0, 32'h44, 16'h0, 2'b00, 4'h6, 1'b1, 5'd3);
        tick();
        tick();
        check("pre_rst_skid_in_ready", bus.in_ready, 1'b0);
`else
        // Reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(5'd1, 32'h303, 5'd0, 32'h44, 16'h0, 2'b00, 4'h6, 1'b1, 5'd3);
        tick();
        check("pre_rst_valid", bus.out_valid, 1'b1);
`endif
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_a", bus.out_a, 32'h0);
        check("mid_rst_b", bus.out_b, 32'h0);
        check("mid_rst_af", bus.out_af, 4'h0);
        check("mid_rst_i", bus.out_i, 1'b0);
        check("mid_rst_rd", bus.out_rd_idx, 5'd0);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", bus.in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter n, default 32, operand width in bits.
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have flush  input  1  discard all held and incoming operations.
REQ-005 SHALL have in_valid  input  1  upstream operation present.
REQ-006 SHALL have in_ready  output  1  stage accepts the operation this cycle.
REQ-007 SHALL have in_rs_idx  input  5  source register index for a.
REQ-008 SHALL have in_rs_val  input  n  register-file value for rs.
REQ-009 SHALL have in_rt_idx  input  5  source register index for b.
REQ-010 SHALL have in_rt_val  input  n  register-file value for rt.
REQ-011 SHALL have in_imm  input  16  instruction immediate.
REQ-012 SHALL have in_imm_mode  input  2  00 use rt, 01 zero-extend imm, 10 sign-extend imm, 11 reserved (treated as 00).
REQ-013 SHALL have in_af  input  4  ALU function code, passed through.
REQ-014 SHALL have in_i  input  1  immediate/LUI qualifier, passed through.
REQ-015 SHALL have in_rd_idx  input  5  destination register index, passed through.
REQ-016 SHALL have fwd_we  input  1  downstream result will be written.
REQ-017 SHALL have fwd_idx  input  5  downstream destination index.
REQ-018 SHALL have fwd_val  input  n  downstream result value.
REQ-019 SHALL have out_valid  output  1  registered operation presented to the ALU.
REQ-020 SHALL have out_ready  input  1  ALU side consumes the operation.
REQ-021 SHALL have out_a, out_b  output  n each  ALU operands a and b.
REQ-022 SHALL have out_af  output  4, out_i  output  1, out_rd_idx  output  5  registered pass-through fields.

Function
REQ-023 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready; accepted operation appears on out_* exactly 1 cycle later (latency 1).
REQ-024 Operand a SHALL be fwd_val when fwd_we & fwd_idx==in_rs_idx & in_rs_idx!=0, else in_rs_val; resolved at acceptance.
REQ-025 Operand b SHALL be: mode 01 {zeros,in_imm}; mode 10 {n-16 copies of in_imm[15],in_imm}; otherwise rt forwarded by the REQ-024 rule using in_rt_idx/in_rt_val.
REQ-026 Index 0 SHALL never forward; operand value comes from in_*_val unchanged.
REQ-027 out_* data SHALL hold stable while out_valid & ~out_ready.
REQ-028 States: EMPTY (out_valid=0), FULL (out reg valid), SKID (out reg and skid reg valid, skid builds only); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain+accept or idle; FULL->SKID on accept without drain; SKID->FULL on drain (skid moves to out reg); no accept in SKID.
REQ-029 Simultaneous accept and drain in FULL SHALL replace out reg without a bubble.
REQ-030 flush SHALL force EMPTY next cycle, ignore in_valid that cycle, and drive in_ready=0 that cycle; flush outranks every other event.
REQ-031 Operand values forwarded into a held entry SHALL NOT be re-resolved later.

Reset
REQ-032 rst SHALL, on the next rising edge, force EMPTY: out_valid=0, out_a=out_b=0, out_af=0, out_i=0, out_rd_idx=0, skid cleared; rst outranks flush and any in-flight transfer.

Configuration
REQ-033 With ALU_ISSUE_SKID_EN defined SHALL implement SKID state and in_ready = ~rst & ~flush & (state!=SKID), registered-only path from out_ready.
REQ-034 Without ALU_ISSUE_SKID_EN SHALL omit skid register and SKID state; in_ready = ~rst & ~flush & (~out_valid | out_ready), combinational from out_ready.

Structure
REQ-035 Shared package SHALL hold immediate-mode constants (IMM_RT, IMM_ZEXT, IMM_SEXT), state encoding, and register-index width 5.
REQ-036 SHALL contain one sub-module operand_select (forwarding plus immediate extension), instantiated for a and b paths.

Verification
REQ-037 rs=3 val 0x5, fwd_we=1 idx=3 val 0x77 -> out_a=0x77 next cycle; fwd_idx=4 -> out_a=0x5.
REQ-038 imm=0x8001 mode 10 -> out_b=0xFFFF8001; mode 01 -> out_b=0x00008001.
REQ-039 rs=0 val 0x0, fwd_we=1 idx=0 val 0xDEAD -> out_a=0x0.
REQ-040 SKID_EN, out_ready=0, two accepts -> second held in skid, in_ready=0; out_ready=1 two cycles -> both emerge in order, no loss.
REQ-041 FULL, flush=1 with in_valid=1 -> out_valid=0 next cycle, operation not accepted.
REQ-042 rst=1 mid-SKID -> next cycle out_valid=0, all out_* 0, in_ready=1 after rst falls.
